// File: rtl/enc_bundler.sv
// Purpose : bundles SEQ_CYCLE_COUNT bound hypervectors per encoding into a majority-binarised query.
// Latency : query_valid_o rises 1 clk after encoding_done_i is sampled with en_i high.
// Backpr. : one-deep output register; a result arriving while the previous one is unaccepted is dropped (overflow_o).
//
// Ports:
//   clk_i, rst_i          rising-edge clock, synchronous active-high reset
//   en_i                  global enable gating both sampling and result events
//   bundling_features_i   bound_hv_i valid this cycle (FSM in bundle state)
//   ctr_i                 FSM sample index, 0 restarts the accumulation
//   encoding_done_i       FSM done pulse, cycle after the last sample
//   bound_hv_i, tie_hv_i  sample hypervector, tie-break hypervector for even splits
//   query_hv_o/_valid_o   binarised result and its valid, consumed with query_ready_i
//   seq_err_o, overflow_o sticky error flags, cleared only by rst_i
module enc_bundler #(
    parameter int DIM             = 64,
    parameter int SEQ_CYCLE_COUNT = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           bundling_features_i,
    input  logic [1:0]     ctr_i,
    input  logic           encoding_done_i,
    input  logic [DIM-1:0] bound_hv_i,
    input  logic [DIM-1:0] tie_hv_i,
    output logic [DIM-1:0] query_hv_o,
    output logic           query_valid_o,
    input  logic           query_ready_i,
    output logic           seq_err_o,
    output logic           overflow_o
);

    localparam int CNT_W = $clog2(SEQ_CYCLE_COUNT + 1);
    localparam logic [CNT_W-1:0] N_C = CNT_W'(SEQ_CYCLE_COUNT);
    localparam logic [CNT_W:0]   N_W = (CNT_W + 1)'(SEQ_CYCLE_COUNT);

    logic [DIM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [DIM-1:0][CNT_W-1:0] cnt_first, cnt_sat;
    logic [CNT_W-1:0]          samples_q, samples_d, samples_inc;
    logic [1:0]                samples_lo;
    logic [DIM-1:0]            query_hv_q, query_hv_d, bin;
    logic                      query_valid_q, query_valid_d;
    logic                      seq_err_q, seq_err_d;
    logic                      overflow_q, overflow_d;
    logic                      sample, result, accept;

    assign sample = bundling_features_i & en_i;
    assign result = encoding_done_i & en_i;
    assign accept = query_valid_q & query_ready_i;

    // ctr_i only carries two bits, so the sequence check looks at the low bits of the count.
    assign samples_lo  = 2'(samples_q);
    assign samples_inc = (samples_q == N_C) ? N_C : samples_q + CNT_W'(1);

    for (genvar i = 0; i < DIM; i++) begin : g_dim
        logic [CNT_W:0] sum;
        logic [CNT_W:0] dbl;

        assign cnt_first[i] = CNT_W'(bound_hv_i[i]);
        // Extra sampled beyond N would overflow CNT_W; clamp so the majority stays meaningful.
        assign sum          = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, bound_hv_i[i]};
        assign cnt_sat[i]   = (sum > N_W) ? N_C : sum[CNT_W-1:0];
        // 2*cnt vs N avoids a division and makes the tie case exact for even N.
        assign dbl          = {cnt_q[i], 1'b0};
        assign bin[i]       = (dbl > N_W) | ((dbl == N_W) & tie_hv_i[i]);
    end

    always_comb begin
        cnt_d         = cnt_q;
        samples_d     = samples_q;
        query_hv_d    = query_hv_q;
        query_valid_d = query_valid_q;
        seq_err_d     = seq_err_q;
        overflow_d    = overflow_q;

        if (sample) begin
            if (ctr_i == 2'd0) begin
                // Restart: any partial accumulation from an aborted encoding is discarded.
                cnt_d     = cnt_first;
                samples_d = CNT_W'(1);
            end else begin
                cnt_d     = cnt_sat;
                samples_d = samples_inc;
                if (samples_q == N_C) begin
                    seq_err_d = 1'b1;
                end
            end
            if (ctr_i != samples_lo) begin
                seq_err_d = 1'b1;
            end
        end

        if (result) begin
            // The result event closes the encoding, so it wins over a coincident sample count.
            samples_d = '0;
            if (samples_q != N_C) begin
                seq_err_d = 1'b1;
            end
            if (!query_valid_q || query_ready_i) begin
                query_hv_d    = bin;
                query_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (accept) begin
            query_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            samples_q     <= '0;
            query_hv_q    <= '0;
            query_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            samples_q     <= samples_d;
            query_hv_q    <= query_hv_d;
            query_valid_q <= query_valid_d;
            seq_err_q     <= seq_err_d;
            overflow_q    <= overflow_d;
        end
    end

    assign query_hv_o    = query_hv_q;
    assign query_valid_o = query_valid_q;
    assign seq_err_o     = seq_err_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_enc_bundler.sv
// Purpose : directed bench for enc_bundler with DIM=8, N=4 and a result scoreboard.
// Latency : expects query_valid one clock after the done pulse is sampled.
// Backpr. : drives query_ready low to exercise hold and drop of a second result.
module tb_enc_bundler;

    localparam int DIM = 8;
    localparam int N   = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           bundling_features;
    logic [1:0]     ctr;
    logic           encoding_done;
    logic [DIM-1:0] bound_hv;
    logic [DIM-1:0] tie_hv;
    logic [DIM-1:0] query_hv;
    logic           query_valid;
    logic           query_ready;
    logic           seq_err;
    logic           overflow;

    int checks = 0;
    int errors = 0;
    int mdl_cnt [DIM];
    logic [DIM-1:0] sb [$];

    enc_bundler #(.DIM(DIM), .SEQ_CYCLE_COUNT(N)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .en_i                (en),
        .bundling_features_i (bundling_features),
        .ctr_i               (ctr),
        .encoding_done_i     (encoding_done),
        .bound_hv_i          (bound_hv),
        .tie_hv_i            (tie_hv),
        .query_hv_o          (query_hv),
        .query_valid_o       (query_valid),
        .query_ready_i       (query_ready),
        .seq_err_o           (seq_err),
        .overflow_o          (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference majority over the samples the bench has driven since the last ctr==0.
    function automatic logic [DIM-1:0] model_result();
        logic [DIM-1:0] r;
        for (int i = 0; i < DIM; i++) begin
            if (2 * mdl_cnt[i] > N)       r[i] = 1'b1;
            else if (2 * mdl_cnt[i] == N) r[i] = tie_hv[i];
            else                          r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic do_sample(input logic [DIM-1:0] hv, input logic [1:0] c);
        bundling_features = 1'b1;
        ctr               = c;
        bound_hv          = hv;
        for (int i = 0; i < DIM; i++) begin
            mdl_cnt[i] = (c == 2'd0) ? int'(hv[i]) : mdl_cnt[i] + int'(hv[i]);
        end
        tick();
        bundling_features = 1'b0;
    endtask

    task automatic do_done(input bit push);
        encoding_done = 1'b1;
        if (push) sb.push_back(model_result());
        tick();
        encoding_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        check({tag, "_hv"},    64'(query_hv),    64'h0);
        check({tag, "_valid"}, 64'(query_valid), 64'h0);
        check({tag, "_seq"},   64'(seq_err),     64'h0);
        check({tag, "_ovf"},   64'(overflow),    64'h0);
        rst = 1'b0;
        for (int i = 0; i < DIM; i++) mdl_cnt[i] = 0;
    endtask

    // Scoreboard: every accepted output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [DIM-1:0] exp;
        if (!rst && query_valid && query_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", query_hv);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                assert (query_hv === exp) else begin
                    errors++;
                    $error("FAIL sb_query_hv observed=%0h expected=%0h", query_hv, exp);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; bundling_features = 1'b0; ctr = 2'd0;
        encoding_done = 1'b0; bound_hv = '0; tie_hv = '0; query_ready = 1'b1;
        for (int i = 0; i < DIM; i++) mdl_cnt[i] = 0;
        tick();
        do_reset("rst0");

        // T1: majority with ties resolved to 0
        tie_hv = 8'h00;
        do_sample(8'hF0, 2'd0); do_sample(8'hCC, 2'd1);
        do_sample(8'hAA, 2'd2); do_sample(8'hFF, 2'd3);
        do_done(1'b1);
        check("t1_valid", 64'(query_valid), 64'h1);
        check("t1_hv",    64'(query_hv),    64'hE8);
        tick();
        check("t1_valid_drop", 64'(query_valid), 64'h0);
        check("t1_seq", 64'(seq_err), 64'h0);

        // T2: same samples, ties resolved to 1
        tie_hv = 8'hFF;
        do_sample(8'hF0, 2'd0); do_sample(8'hCC, 2'd1);
        do_sample(8'hAA, 2'd2); do_sample(8'hFF, 2'd3);
        do_done(1'b1);
        check("t2_valid", 64'(query_valid), 64'h1);
        check("t2_hv",    64'(query_hv),    64'hFE);
        tick();

        // T3: backpressure, second result dropped
        tie_hv = 8'h00;
        query_ready = 1'b0;
        do_sample(8'h0F, 2'd0); do_sample(8'h0F, 2'd1);
        do_sample(8'h33, 2'd2); do_sample(8'h00, 2'd3);
        do_done(1'b1);
        check("t3_valid", 64'(query_valid), 64'h1);
        for (int k = 0; k < 4; k++) do_sample(8'hFF, 2'(k));
        check("t3_hold_hv", 64'(query_hv), 64'h03);
        do_done(1'b0);
        check("t3_ovf",       64'(overflow),    64'h1);
        check("t3_hv_kept",   64'(query_hv),    64'h03);
        check("t3_valid_kept",64'(query_valid), 64'h1);
        query_ready = 1'b1;
        tick();
        check("t3_valid_drop", 64'(query_valid), 64'h0);

        // T4: done coincides with accept, second result loaded back-to-back
        do_reset("rst1");
        query_ready = 1'b0;
        for (int k = 0; k < 4; k++) do_sample(8'hAA, 2'(k));
        do_done(1'b1);
        for (int k = 0; k < 4; k++) do_sample(8'h55, 2'(k));
        query_ready = 1'b1;
        do_done(1'b1);
        check("t4_valid", 64'(query_valid), 64'h1);
        check("t4_hv",    64'(query_hv),    64'h55);
        check("t4_ovf",   64'(overflow),    64'h0);
        tick();
        check("t4_valid_drop", 64'(query_valid), 64'h0);

        // T5a: ctr out of order
        do_sample(8'h01, 2'd0); do_sample(8'h03, 2'd1);
        check("t5_seq_ok", 64'(seq_err), 64'h0);
        do_sample(8'h07, 2'd3);
        check("t5_seq_ooo", 64'(seq_err), 64'h1);
        do_sample(8'h0F, 2'd2);
        do_done(1'b1);
        check("t5_valid", 64'(query_valid), 64'h1);
        tick();

        // T5b: short encoding, 3 samples only
        do_reset("rst2");
        tie_hv = 8'hF0;
        do_sample(8'hFF, 2'd0); do_sample(8'hFF, 2'd1); do_sample(8'h00, 2'd2);
        check("t5b_seq_pre", 64'(seq_err), 64'h0);
        do_done(1'b1);
        check("t5b_seq", 64'(seq_err),     64'h1);
        check("t5b_valid", 64'(query_valid), 64'h1);
        tick();

        // T6: reset mid-bundle then clean encoding
        do_reset("rst3");
        tie_hv = 8'h0F;
        do_sample(8'hFF, 2'd0); do_sample(8'hFF, 2'd1);
        do_reset("t6_rst");
        do_sample(8'h3C, 2'd0); do_sample(8'h3C, 2'd1);
        do_sample(8'h00, 2'd2); do_sample(8'hC3, 2'd3);
        do_done(1'b1);
        check("t6_valid", 64'(query_valid), 64'h1);
        check("t6_seq",   64'(seq_err),     64'h0);
        tick();
        check("t6_valid_drop", 64'(query_valid), 64'h0);
        tick();

        check("sb_left", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
